sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO that generalises the team's 8x8 FIFO to any data width and power-of-two depth. Adds:
- an occupancy count and programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags;
- a selectable first-word-fall-through (FWFT) read mode.

It is the general buffering element between same-clock pipeline stages. The async FIFO remains the choice for clock crossings.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (ADDR_W >= 1)
AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read request (pop)
clr_err  in  1  clears sticky error flags
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data holds a valid word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (asynchronous, rst=1) clears the following:
  - wr_ptr, rd_ptr and count go to 0; rd_data and rd_valid go to 0; overflow and underflow go to 0.
  - Resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data; the first write after reset lands at address 0.
- Pointers are ADDR_W+1 bits. The address is the low ADDR_W bits. Both pointers wrap naturally modulo 2*DEPTH.
- Write accept: wr_acc = wr_en & ~full. The word is stored at wr_ptr on the clock edge and wr_ptr increments. There is no write-through when full, even if a read occurs in the same cycle.
- Read accept: rd_acc = rd_en & ~empty, and rd_ptr increments.
- count update:
  - +1 on wr_acc only; -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
  - count is registered; all status flags are combinational decodes of count only.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data is registered with mem[rd_addr] at the edge, giving 1-cycle latency.
  - rd_valid=1 for exactly the cycle after each rd_acc, and 0 otherwise.
  - rd_data holds its last value when there is no read.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_addr] (asynchronous array read); rd_valid = ~empty.
  - rd_en acts as a pop/acknowledge of the presented word.
  - A word written into an empty FIFO is visible, with rd_valid=1, in the cycle after the write edge.
- Empty + simultaneous rd_en/wr_en:
  - The write is accepted and the read is rejected; underflow is set.
  - count becomes 1.
- Full + simultaneous rd_en/wr_en:
  - The read is accepted and the write is rejected; overflow is set.
  - count becomes DEPTH-1.
- Sticky errors:
  - overflow is set on wr_en & full; underflow is set on rd_en & empty.
  - clr_err clears both; a set in the same cycle as clr_err takes priority.
  - The errors never block further operation.
- Parameter legality (AF_LEVEL, AE_LEVEL ranges) is checked at elaboration; an illegal value stops elaboration with an error.

Decomposition:
- Shared package fifo_pkg:
  - clog2 helper function;
  - FIFO mode constants FIFO_STD=0 and FIFO_FWFT=1;
  - default DATA_W/ADDR_W values.
- One sub-module, fifo_ram_2p(DATA_W, ADDR_W, ASYNC_RD):
  - one synchronous write port;
  - one read port, registered when ASYNC_RD=0 and combinational when ASYNC_RD=1.
- Pointer, count, flag and error logic stay in sync_fifo_param.

Test Plan:
1. Reset: assert rst mid-stream with count=5 -> immediately count=0, empty=1, almost_empty=1, rd_valid=0, overflow=0. A subsequent write of 0x3C then read returns 0x3C.
2. Fill (DEPTH=8, AF=6): write 0x10..0x17 -> almost_full rises after the 6th edge and full after the 8th, count=8. A 9th write of 0xFF is dropped and overflow=1. Pulsing clr_err clears overflow.
3. Drain (FWFT=0): 8 reads -> rd_data=0x10..0x17, each one cycle after its rd_en with a 1-cycle rd_valid pulse; empty after the 8th. A 9th rd_en gives rd_valid=0 and underflow=1.
4. Concurrent traffic: at count=4, 10 cycles of rd_en=wr_en=1 -> count stays 4 and output order equals input order. Then at full, rd_en=wr_en=1 -> count=7 and overflow=1.
5. Wrap-around: 40 randomly gated writes/reads with a reference-queue scoreboard -> zero mismatches, and the pointers wrap at least twice.
6. FWFT=1: write 0xA5 into an empty FIFO -> next cycle rd_valid=1, rd_data=0xA5 with no rd_en. Pulse rd_en -> rd_valid=0 and empty=1 in the following cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
//   FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter
//   DEF_DATA_W / DEF_ADDR_W : default geometry (8-bit x 8-entry)
//   clog2() : ceiling log2, usable in constant expressions
package fifo_pkg;

  localparam int unsigned FIFO_STD   = 0;
  localparam int unsigned FIFO_FWFT  = 1;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 3;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Two-port storage array for the FIFO: one synchronous write port and one
// read port that is either registered (ASYNC_RD=0) or combinational
// (ASYNC_RD=1). Only the registered read output is reset; the array is not.
//   clk, rst            : clock, async active-high reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr       : read port (rd_en ignored when ASYNC_RD=1)
//   rd_data             : read data
module fifo_ram_2p
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ASYNC_RD = FIFO_STD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  generate
    if (ASYNC_RD != 0) begin : g_async_rd
      logic unused_rd_ctrl;
      assign unused_rd_ctrl = rst ^ rd_en;
      assign rd_data = mem[rd_addr];
    end else begin : g_sync_rd
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
      end
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags and selectable FWFT read mode.
//   clk, rst      : clock, async active-high reset
//   wr_en/wr_data : push request and data (dropped when full)
//   rd_en         : pop request (ignored when empty)
//   clr_err       : clears overflow/underflow (a same-cycle set wins)
//   rd_data/rd_valid : read word and its qualifier
//   full/empty/almost_full/almost_empty : decodes of count
//   count         : occupancy 0..DEPTH
//   overflow/underflow : sticky error flags
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = FIFO_STD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned     DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  generate
    if (DATA_W == 0) begin : g_bad_data_w
      $error("sync_fifo_param: DATA_W must be >= 1");
    end
    if (ADDR_W == 0 || clog2(DEPTH) != ADDR_W) begin : g_bad_addr_w
      $error("sync_fifo_param: ADDR_W out of range");
    end
    if (AF_LEVEL == 0 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_bad_ae
      $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
    end
    if (FWFT > FIFO_FWFT) begin : g_bad_fwft
      $error("sync_fifo_param: FWFT must be 0 or 1");
    end
  endgenerate

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            wr_acc;
  logic            rd_acc;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // A new error event outranks clr_err in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & full)  | (overflow  & ~clr_err);
      underflow <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

  fifo_ram_2p #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ASYNC_RD (FWFT)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // In FWFT mode the head word is always presented, so validity is simply
  // "not empty"; otherwise it marks the cycle after an accepted pop.
  generate
    if (FWFT != 0) begin : g_fwft_valid
      assign rd_valid = ~empty;
    end else begin : g_std_valid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_valid <= 1'b0;
        else     rd_valid <= rd_acc;
      end
    end
  endgenerate

endmodule
